// File: rtl/gctr_decrypt_n_blocks.sv
// GCTR (AES-CTR) decryption of N_BLOCKS 128-bit blocks per word over fixed-latency AES ladders.
// Define GCTR_DEC_TAIL_ZERO_EN to force plaintext bytes outside o_byte_mask to 0x00.

// AES encryption of one block from a pre-expanded key; latency N_ROUNDS+1 cycles.
module aes_round_ladder #(
  parameter int NB_BLOCK = 128,
  parameter int N_ROUNDS = 14
) (
  input  logic                             clock,
  input  logic                             enable,
  input  logic [NB_BLOCK*(N_ROUNDS+1)-1:0] round_keys,
  input  logic [NB_BLOCK-1:0]              block_in,
  output logic [NB_BLOCK-1:0]              block_out
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Inverse as x^254 followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x240, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < 16; j++) b[j] = sbox(s[127-8*j -: 8]);
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) t[4*c+rr] = b[4*((c+rr)%4)+rr];
    end
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c];
      a1 = t[4*c+1];
      a2 = t[4*c+2];
      a3 = t[4*c+3];
      if (last) begin
        r[127-32*c -: 32] = {a0, a1, a2, a3};
      end else begin
        r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
    end
    return r ^ rk;
  endfunction

  logic [NB_BLOCK-1:0] stage_q [N_ROUNDS+1];

  always_ff @(posedge clock) begin
    if (enable) begin
      stage_q[0] <= block_in ^ round_keys[0 +: NB_BLOCK];
      for (int r = 1; r <= N_ROUNDS; r++) begin
        stage_q[r] <= aes_round(stage_q[r-1], round_keys[r*NB_BLOCK +: NB_BLOCK],
                                r == N_ROUNDS);
      end
    end
  end

  assign block_out = stage_q[N_ROUNDS];

endmodule

module gctr_decrypt_n_blocks #(
  parameter int NB_BLOCK       = 128,
  parameter int N_ROUNDS       = 14,
  parameter int N_BLOCKS       = 2,
  parameter int NB_DATA        = N_BLOCKS * NB_BLOCK,
  parameter int LADDER_LATENCY = 15
) (
  input  logic                             i_clock,
  input  logic                             i_reset_n,
  input  logic [NB_DATA-1:0]               i_ciphertext_words,
  input  logic [NB_BLOCK*(N_ROUNDS+1)-1:0] i_round_key_vector,
  input  logic [NB_BLOCK-1:0]              i_j0,
  input  logic                             i_valid,
  input  logic                             i_sop,
  input  logic                             i_eop,
  input  logic [$clog2(N_BLOCKS*16):0]     i_last_nbytes,
  output logic [NB_DATA-1:0]               o_plaintext_words,
  output logic                             o_valid,
  output logic                             o_sop,
  output logic                             o_eop,
  output logic [N_BLOCKS*16-1:0]           o_byte_mask,
  output logic                             o_err
);

  localparam int NBYTES = N_BLOCKS * 16;

  typedef enum logic {StIdle, StActive} state_t;

  state_t              state_q, state_d;
  logic [NB_BLOCK-1:0] base_q, base_d, base_cur;
  logic                accept, err_d, err_q, nbytes_bad;
  logic [NBYTES-1:0]   mask_in;
  logic [NB_BLOCK-1:0] ctr    [N_BLOCKS];
  logic [NB_BLOCK-1:0] ks_blk [N_BLOCKS];
  logic [NB_DATA-1:0]  ks;

  logic [LADDER_LATENCY-1:0] vld_q, sop_q, eop_q;
  logic [NBYTES-1:0]         mask_q [LADDER_LATENCY];
  logic [NB_DATA-1:0]        ct_q   [LADDER_LATENCY];

  function automatic logic [NB_BLOCK-1:0] inc32_by(input logic [NB_BLOCK-1:0] b,
                                                   input logic [31:0] n);
    return {b[NB_BLOCK-1:32], b[31:0] + n};
  endfunction

  // A sop word counts from the fresh J0 in the same cycle it is sampled.
  assign base_cur   = (i_valid && i_sop) ? inc32_by(i_j0, 32'd1) : base_q;
  assign nbytes_bad = (i_last_nbytes == '0) || (int'(i_last_nbytes) > NBYTES);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    err_d   = 1'b0;
    accept  = 1'b0;
    if (i_valid) begin
      if (i_sop || state_q == StActive) begin
        accept  = 1'b1;
        base_d  = inc32_by(base_cur, 32'(N_BLOCKS));
        state_d = i_eop ? StIdle : StActive;
        if (i_sop && state_q == StActive) err_d = 1'b1;
        if (i_eop && nbytes_bad) err_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_comb begin
    mask_in = '0;
    for (int k = 0; k < NBYTES; k++) begin
      mask_in[k] = !i_eop || nbytes_bad || (k < int'(i_last_nbytes));
    end
  end

  for (genvar ii = 0; ii < N_BLOCKS; ii++) begin : g_blk
    assign ctr[ii] = inc32_by(base_cur, 32'(ii));
    aes_round_ladder #(
      .NB_BLOCK(NB_BLOCK),
      .N_ROUNDS(N_ROUNDS)
    ) u_ladder (
      .clock     (i_clock),
      .enable    (1'b1),
      .round_keys(i_round_key_vector),
      .block_in  (ctr[ii]),
      .block_out (ks_blk[ii])
    );
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      base_q  <= '0;
      err_q   <= 1'b0;
      vld_q   <= '0;
      sop_q   <= '0;
      eop_q   <= '0;
      for (int s = 0; s < LADDER_LATENCY; s++) mask_q[s] <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      err_q     <= err_d;
      vld_q     <= {vld_q[LADDER_LATENCY-2:0], accept};
      sop_q     <= {sop_q[LADDER_LATENCY-2:0], accept & i_sop};
      eop_q     <= {eop_q[LADDER_LATENCY-2:0], accept & i_eop};
      mask_q[0] <= accept ? mask_in : '0;
      for (int s = 1; s < LADDER_LATENCY; s++) mask_q[s] <= mask_q[s-1];
    end
  end

  always_ff @(posedge i_clock) begin
    ct_q[0] <= i_ciphertext_words;
    for (int s = 1; s < LADDER_LATENCY; s++) ct_q[s] <= ct_q[s-1];
  end

  always_comb begin
    ks = '0;
    for (int ii = 0; ii < N_BLOCKS; ii++) ks[ii*NB_BLOCK +: NB_BLOCK] = ks_blk[ii];
  end

  always_comb begin
    o_plaintext_words = ks ^ ct_q[LADDER_LATENCY-1];
`ifdef GCTR_DEC_TAIL_ZERO_EN
    for (int k = 0; k < NBYTES; k++) begin
      if (!mask_q[LADDER_LATENCY-1][k]) o_plaintext_words[8*k +: 8] = 8'h00;
    end
`endif
  end

  assign o_valid     = vld_q[LADDER_LATENCY-1];
  assign o_sop       = sop_q[LADDER_LATENCY-1];
  assign o_eop       = eop_q[LADDER_LATENCY-1];
  assign o_byte_mask = mask_q[LADDER_LATENCY-1];
  assign o_err       = err_q;

endmodule

// File: tb/tb_gctr_decrypt_n_blocks.sv
// Scoreboard bench for gctr_decrypt_n_blocks with an independent AES-256 reference model.
// Expected tail bytes follow GCTR_DEC_TAIL_ZERO_EN when the build defines it.
module tb_gctr_decrypt_n_blocks;

  typedef struct {
    int unsigned  cyc;
    logic         sop;
    logic         eop;
    logic [31:0]  mask;
    logic [255:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [255:0]  ct;
  logic [1919:0] rkv;
  logic [127:0]  j0;
  logic          valid, sop, eop;
  logic [5:0]    nbytes;
  logic [255:0]  out_pt;
  logic          out_valid, out_sop, out_eop, out_err;
  logic [31:0]   out_mask;

  int unsigned   cyc = 0;
  int            n_checks = 0;
  int            n_errors = 0;
  exp_t          sb[$];
  int unsigned   err_sb[$];
  logic          m_active = 1'b0;
  logic [127:0]  m_base = '0;
  logic [127:0]  last_blk0 = '0;
  logic [7:0]    sbox_t [256];

  gctr_decrypt_n_blocks dut (
    .i_clock           (clk),
    .i_reset_n         (rst_n),
    .i_ciphertext_words(ct),
    .i_round_key_vector(rkv),
    .i_j0              (j0),
    .i_valid           (valid),
    .i_sop             (sop),
    .i_eop             (eop),
    .i_last_nbytes     (nbytes),
    .o_plaintext_words (out_pt),
    .o_valid           (out_valid),
    .o_sop             (out_sop),
    .o_eop             (out_eop),
    .o_byte_mask       (out_mask),
    .o_err             (out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
    return p[7:0];
  endfunction

  task automatic init_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++) begin
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
      end
      sbox_t[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [1919:0] expand_key(input logic [255:0] key);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] v;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) t = {t[23:0], t[31:24]};
      if (i % 8 == 0 || i % 8 == 4) begin
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
      end
      if (i % 8 == 0) begin
        t = t ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) v[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return v;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] blk, input logic [1919:0] keys);
    logic [7:0]   st  [4][4];
    logic [7:0]   tmp [4][4];
    logic [127:0] rk;
    logic [127:0] res;
    rk = keys[0 +: 128];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) st[r][c] = blk[127-8*(4*c+r) -: 8] ^ rk[127-8*(4*c+r) -: 8];
    for (int rnd = 1; rnd <= 14; rnd++) begin
      rk = keys[rnd*128 +: 128];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) tmp[r][c] = sbox_t[st[r][(c+r)%4]];
      for (int c = 0; c < 4; c++) begin
        if (rnd < 14) begin
          st[0][c] = gmul(8'h02, tmp[0][c]) ^ gmul(8'h03, tmp[1][c]) ^ tmp[2][c] ^ tmp[3][c];
          st[1][c] = tmp[0][c] ^ gmul(8'h02, tmp[1][c]) ^ gmul(8'h03, tmp[2][c]) ^ tmp[3][c];
          st[2][c] = tmp[0][c] ^ tmp[1][c] ^ gmul(8'h02, tmp[2][c]) ^ gmul(8'h03, tmp[3][c]);
          st[3][c] = gmul(8'h03, tmp[0][c]) ^ tmp[1][c] ^ tmp[2][c] ^ gmul(8'h02, tmp[3][c]);
        end else begin
          for (int r = 0; r < 4; r++) st[r][c] = tmp[r][c];
        end
      end
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) st[r][c] = st[r][c] ^ rk[127-8*(4*c+r) -: 8];
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) res[127-8*(4*c+r) -: 8] = st[r][c];
    return res;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Models one word on the current cycle, queues its expected effects, then holds it a cycle.
  task automatic drive(input logic v, input logic s, input logic e, input logic [5:0] nb,
                       input logic [255:0] c, input logic [127:0] j);
    exp_t         x;
    logic [127:0] cur;
    logic         bad, err;
    int           n_eff;
    err = v && (s ? m_active : !m_active);
    if (v && (s || m_active)) begin
      cur    = s ? {j[127:32], j[31:0] + 32'd1} : m_base;
      bad    = e && (nb == 6'd0 || nb > 6'd32);
      err    = err || bad;
      n_eff  = (e && !bad) ? int'(nb) : 32;
      x.mask = (n_eff == 32) ? 32'hffff_ffff : ((32'd1 << n_eff) - 32'd1);
      x.data = c ^ {aes_enc({cur[127:32], cur[31:0] + 32'd1}, rkv), aes_enc(cur, rkv)};
`ifdef GCTR_DEC_TAIL_ZERO_EN
      for (int k = 0; k < 32; k++) if (!x.mask[k]) x.data[8*k +: 8] = 8'h00;
`endif
      x.sop = s;
      x.eop = e;
      x.cyc = cyc + 15;
      sb.push_back(x);
      m_base   = {cur[127:32], cur[31:0] + 32'd2};
      m_active = !e;
    end
    if (err) err_sb.push_back(cyc + 1);
    valid  = v;
    sop    = s;
    eop    = e;
    nbytes = nb;
    ct     = c;
    j0     = j;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 6'd0, '0, '0);
  endtask

  task automatic reset_pulse();
    valid = 1'b0;
    #2 rst_n = 1'b0;
    sb.delete();
    err_sb.delete();
    m_active = 1'b0;
    m_base   = '0;
    @(negedge clk);
    check_val("midrst_valid", out_valid, 0);
    check_val("midrst_err", out_err, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (out_valid) begin
      last_blk0 = out_pt[127:0];
      if (sb.size() == 0) begin
        check_val("spurious_valid", out_valid, 0);
      end else begin
        e = sb.pop_front();
        check_val("latency", cyc, e.cyc);
        check_val("o_sop", out_sop, e.sop);
        check_val("o_eop", out_eop, e.eop);
        check_val("o_byte_mask", out_mask, e.mask);
        check_val("plaintext", out_pt, e.data);
      end
    end
    if (out_err) begin
      if (err_sb.size() == 0) check_val("spurious_err", out_err, 0);
      else check_val("err_cycle", cyc, err_sb.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] jr;
    int           len;
    valid = 1'b0; sop = 1'b0; eop = 1'b0; nbytes = '0; ct = '0; j0 = '0; rkv = '0;
    init_sbox();
    repeat (3) @(negedge clk);
    check_val("rst_valid", out_valid, 0);
    check_val("rst_sop", out_sop, 0);
    check_val("rst_eop", out_eop, 0);
    check_val("rst_err", out_err, 0);
    check_val("rst_mask", out_mask, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_valid", out_valid, 0);

    // Known-answer: counter block equals the published AES-256 plaintext.
    rkv = expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    drive(1'b1, 1'b1, 1'b1, 6'd32, '0, 128'h00112233445566778899aabbccddeefe);
    idle(20);
    check_val("fips197_blk0", last_blk0, 128'h8ea2b7ca516745bfeafc49904b496089);

    rkv = '0;
    drive(1'b1, 1'b1, 1'b0, 6'd32, '0, 128'hcafebabefacedbaddecaf88800000001);
    drive(1'b1, 1'b0, 1'b1, 6'd20, rand256(), '0);
    drive(1'b1, 1'b0, 1'b0, 6'd32, rand256(), '0);
    idle(20);

    rkv = expand_key(rand256());
    jr  = {rand256()[95:0], 32'hffff_fffe};
    drive(1'b1, 1'b1, 1'b0, 6'd32, rand256(), jr);
    idle(2);
    drive(1'b1, 1'b0, 1'b1, 6'd32, rand256(), '0);
    drive(1'b1, 1'b1, 1'b0, 6'd32, rand256(), rand256()[127:0]);
    drive(1'b1, 1'b1, 1'b0, 6'd32, rand256(), rand256()[127:0]);
    drive(1'b1, 1'b0, 1'b1, 6'd7, rand256(), '0);
    drive(1'b1, 1'b1, 1'b1, 6'd0, rand256(), rand256()[127:0]);
    drive(1'b1, 1'b1, 1'b1, 6'd40, rand256(), rand256()[127:0]);
    drive(1'b1, 1'b1, 1'b1, 6'd1, rand256(), rand256()[127:0]);
    idle(20);

    drive(1'b1, 1'b1, 1'b0, 6'd32, rand256(), rand256()[127:0]);
    drive(1'b1, 1'b0, 1'b0, 6'd32, rand256(), '0);
    reset_pulse();
    idle(20);
    drive(1'b1, 1'b1, 1'b0, 6'd32, rand256(), rand256()[127:0]);
    drive(1'b1, 1'b0, 1'b1, 6'd16, rand256(), '0);
    idle(20);

    for (int m = 0; m < 6; m++) begin
      len = $urandom_range(1, 4);
      jr  = rand256()[127:0];
      for (int w = 0; w < len; w++) begin
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        drive(1'b1, w == 0, w == len - 1, 6'($urandom_range(1, 32)), rand256(), jr);
      end
    end
    idle(20);

    check_val("sb_left", sb.size(), 0);
    check_val("err_left", err_sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/gctr_decrypt_n_blocks.md
GCTR_DECRYPT_N_BLOCKS -- requirements
Module: gctr_decrypt_n_blocks

Interface
REQ-001 SHALL have parameter NB_BLOCK, default 128, AES block width in bits.
REQ-002 SHALL have parameter N_ROUNDS, default 14, AES-256 round count.
REQ-003 SHALL have parameter N_BLOCKS, default 2, 128-bit blocks per input word.
REQ-004 SHALL have parameter NB_DATA, default N_BLOCKS*NB_BLOCK, data word width.
REQ-005 SHALL have parameter LADDER_LATENCY, default 15, fixed cycles through aes_round_ladder with enable tied high.
REQ-006 SHALL have port i_clock  in  1  sole clock; all state updates on rising edge.
REQ-007 SHALL have port i_reset_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port i_ciphertext_words  in  NB_DATA  ciphertext; block ii in bits [ii*128 +: 128].
REQ-009 SHALL have port i_round_key_vector  in  NB_BLOCK*(N_ROUNDS+1)  expanded key, static per message.
REQ-010 SHALL have port i_j0  in  NB_BLOCK  pre-counter block J0, sampled on i_sop.
REQ-011 SHALL have port i_valid / i_sop / i_eop  in  1 each  word qualifier, first word, last word.
REQ-012 SHALL have port i_last_nbytes  in  $clog2(N_BLOCKS*16)+1  valid bytes in the i_eop word (1..N_BLOCKS*16).
REQ-013 SHALL have port o_plaintext_words  out  NB_DATA  recovered plaintext.
REQ-014 SHALL have ports o_valid / o_sop / o_eop  out  1 each  and o_byte_mask  out  N_BLOCKS*16  per-byte valid mask (bit k = byte k, LSB first).
REQ-015 SHALL have port o_err  out  1  one-cycle protocol-error pulse.

Function
REQ-016 SHALL run a 2-state FSM: IDLE, ACTIVE.
REQ-017 IDLE + i_valid&i_sop SHALL load counter base = inc32(i_j0) and enter ACTIVE; if i_eop is also high, SHALL stay IDLE.
REQ-018 ACTIVE + i_valid&i_eop SHALL return to IDLE after that word.
REQ-019 IDLE + i_valid without i_sop SHALL drop the word (no output) and pulse o_err.
REQ-020 ACTIVE + i_valid&i_sop SHALL pulse o_err and restart the message with the new J0.
REQ-021 Counter for block ii of a word SHALL be base incremented ii times by inc32; after each valid word, base SHALL advance by N_BLOCKS inc32 steps.
REQ-022 inc32 SHALL increment bits [31:0] modulo 2^32 and leave bits [127:32] unchanged.
REQ-023 Each block SHALL be encrypted by one aes_round_ladder instance; plaintext block = ladder output XOR ciphertext block delayed LADDER_LATENCY cycles.
REQ-024 o_valid, o_sop, o_eop, o_byte_mask SHALL equal the accepted input qualifiers delayed exactly LADDER_LATENCY cycles; dropped words SHALL NOT appear.
REQ-025 o_byte_mask SHALL be all-ones for non-eop words and the lowest i_last_nbytes bits set for eop words.
REQ-026 i_valid low cycles SHALL NOT advance the counter; back-to-back valid words SHALL be accepted every cycle (no backpressure).
REQ-027 i_last_nbytes outside 1..N_BLOCKS*16 on an eop word SHALL be treated as N_BLOCKS*16 and pulse o_err.

Reset
REQ-028 Assertion of i_reset_n low SHALL immediately force FSM to IDLE, counter base to 0, delay line qualifiers to 0.
REQ-029 During and after reset, o_valid, o_sop, o_eop, o_err SHALL be 0 and o_byte_mask 0; o_plaintext_words is don't-care when o_valid=0.
REQ-030 Reset mid-message SHALL discard all in-flight words; no output SHALL appear for them after release.

Configuration
REQ-031 With GCTR_DEC_TAIL_ZERO_EN defined, plaintext bytes with o_byte_mask bit 0 SHALL be forced to 0x00.
REQ-032 Without GCTR_DEC_TAIL_ZERO_EN, such bytes SHALL carry raw keystream XOR ciphertext; mask still produced.

Verification
REQ-033 sop word, J0=cafebabefacedbaddecaf888_00000001, zero key, zero ciphertext -> block0 = AES(…00000002), block1 = AES(…00000003), o_valid exactly 15 cycles later.
REQ-034 J0 low word FFFFFFFE, 2-word message -> counters FFFFFFFF, 00000000, 00000001, 00000002; upper 96 bits unchanged.
REQ-035 eop word with i_last_nbytes=20, macro defined -> o_byte_mask=0x000FFFFF, bytes 20..31 of plaintext = 0x00.
REQ-036 i_valid without i_sop in IDLE -> o_err pulse next cycle, no o_valid ever for that word.
REQ-037 i_reset_n low for one cycle mid 4-word message -> no further o_valid; next sop message decrypts correctly.
REQ-038 encrypt with gctr_function_n_blocks using counter inc32(J0), decrypt here -> original plaintext recovered bit-exact.
